// File: rtl/regfile_sched.sv
// Write scheduler for the renaming register file: shares the busy-array write path
// between issue and commit, tracks busy/tag ownership, and sweeps busy clear after reset/flush.
module regfile_sched #(
  parameter int data_width = 16,
  parameter int tag_width  = 3,
  parameter int num_regs   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [2:0]            issue_dest,
  input  logic [tag_width-1:0]  issue_tag,
  output logic                  issue_ready,
  input  logic                  commit_valid,
  input  logic [2:0]            commit_dest,
  input  logic [tag_width-1:0]  commit_tag,
  input  logic [data_width-1:0] commit_value,
  output logic                  commit_ready,
  output logic                  ld_busy_ic,
  output logic                  ld_rob_entry,
  output logic [2:0]            dest_ic,
  output logic [tag_width-1:0]  rob_entry_in,
  output logic                  ld_busy_rob,
  output logic                  ld_value,
  output logic [2:0]            dest_rob,
  output logic [data_width-1:0] value_in
);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t                               state_q, state_d;
  logic [2:0]                           cnt_q, cnt_d;
  logic [num_regs-1:0]                  busy_q, busy_d;
  logic [num_regs-1:0][tag_width-1:0]   tag_q, tag_d;
  logic                                 pend_v_q, pend_v_d;
  logic [2:0]                           pend_reg_q, pend_reg_d;

  logic issue_acc, commit_acc, match;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    tag_d        = tag_q;
    pend_v_d     = pend_v_q;
    pend_reg_d   = pend_reg_q;
    issue_ready  = 1'b0;
    commit_ready = 1'b0;
    ld_busy_ic   = 1'b0;
    ld_rob_entry = 1'b0;
    dest_ic      = '0;
    rob_entry_in = '0;
    ld_busy_rob  = 1'b0;
    ld_value     = 1'b0;
    dest_rob     = '0;
    value_in     = '0;
    issue_acc    = 1'b0;
    commit_acc   = 1'b0;
    match        = busy_q[commit_dest] && (tag_q[commit_dest] == commit_tag);

    if (reset || flush) begin
      // Any in-flight pending clear is dropped; the sweep clears everything anyway.
      state_d  = SWEEP;
      cnt_d    = '0;
      pend_v_d = 1'b0;
      busy_d   = '0;
    end else if (state_q == SWEEP) begin
      ld_busy_rob = 1'b1;
      dest_rob    = cnt_q;
      cnt_d       = cnt_q + 3'd1;
      if (cnt_q == 3'(num_regs - 1)) state_d = RUN;
    end else if (pend_v_q) begin
      ld_busy_rob = 1'b1;
      dest_rob    = pend_reg_q;
      pend_v_d    = 1'b0;
    end else begin
      issue_ready  = 1'b1;
      commit_ready = 1'b1;
      issue_acc    = issue_valid;
      commit_acc   = commit_valid;

      if (commit_acc) begin
        ld_value = 1'b1;
        dest_rob = commit_dest;
        value_in = commit_value;
        if (match && !issue_acc) begin
          ld_busy_rob         = 1'b1;
          busy_d[commit_dest] = 1'b0;
        end else if (match && (commit_dest != issue_dest)) begin
          // Busy write port is taken by the issue; replay the clear next cycle.
          busy_d[commit_dest] = 1'b0;
          pend_v_d            = 1'b1;
          pend_reg_d          = commit_dest;
        end
      end

      if (issue_acc) begin
        ld_busy_ic         = 1'b1;
        ld_rob_entry       = 1'b1;
        dest_ic            = issue_dest;
        rob_entry_in       = issue_tag;
        busy_d[issue_dest] = 1'b1;
        tag_d[issue_dest]  = issue_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_q      <= tag_d;
    pend_reg_q <= pend_reg_d;
    if (reset) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      busy_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule

// File: tb/tb_regfile_sched.sv
// Directed table-driven bench for regfile_sched: one vector per clock cycle,
// outputs compared combinationally just after the falling edge.
module tb_regfile_sched;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        issue_valid, commit_valid;
  logic [2:0]  issue_dest, issue_tag, commit_dest, commit_tag;
  logic [15:0] commit_value;
  logic        issue_ready, commit_ready, ld_busy_ic, ld_rob_entry, ld_busy_rob, ld_value;
  logic [2:0]  dest_ic, rob_entry_in, dest_rob;
  logic [15:0] value_in;

  int n_run = 0;
  int n_fail = 0;

  regfile_sched dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_tag(issue_tag),
    .issue_ready(issue_ready),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
    .commit_value(commit_value), .commit_ready(commit_ready),
    .ld_busy_ic(ld_busy_ic), .ld_rob_entry(ld_rob_entry), .dest_ic(dest_ic),
    .rob_entry_in(rob_entry_in), .ld_busy_rob(ld_busy_rob), .ld_value(ld_value),
    .dest_rob(dest_rob), .value_in(value_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, fl, iv, cv;
    logic [2:0]  id, it, cd, ct;
    logic [15:0] cval;
    logic [30:0] exp;
  } vec_t;

  vec_t tbl[$];

  // exp = {issue_ready, commit_ready, ld_busy_ic, ld_rob_entry, dest_ic, rob_entry_in,
  //        ld_busy_rob, ld_value, dest_rob, value_in}
  function automatic vec_t mk(input string name, input logic rst, input logic fl,
                              input logic iv, input logic [2:0] id, input logic [2:0] it,
                              input logic cv, input logic [2:0] cd, input logic [2:0] ct,
                              input logic [15:0] cval,
                              input logic rdy, input logic lbi, input logic [2:0] dic,
                              input logic [2:0] rei, input logic lbr, input logic lv,
                              input logic [2:0] dr, input logic [15:0] vi);
    vec_t v;
    v.name = name; v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.it = it;
    v.cv = cv; v.cd = cd; v.ct = ct; v.cval = cval;
    v.exp = {rdy, rdy, lbi, lbi, dic, rei, lbr, lv, dr, vi};
    return v;
  endfunction

  function automatic vec_t sweep(input string name, input logic [2:0] i);
    // Issue/commit presented during the sweep must be ignored.
    return mk(name, 0, 0, 1, 3'd5, 3'd1, 1, 3'd5, 3'd1, 16'h0F0F, 0, 0, 0, 0, 1, 0, i, 16'h0);
  endfunction

  function automatic vec_t idle(input string name);
    return mk(name, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
  endfunction

  function automatic vec_t issue(input string name, input logic [2:0] d, input logic [2:0] t);
    return mk(name, 0, 0, 1, d, t, 0, 0, 0, 16'h0, 1, 1, d, t, 0, 0, 0, 16'h0);
  endfunction

  function automatic vec_t commit(input string name, input logic [2:0] d, input logic [2:0] t,
                                  input logic [15:0] val, input logic clr);
    return mk(name, 0, 0, 0, 0, 0, 1, d, t, val, 1, 0, 0, 0, clr, 1, d, val);
  endfunction

  task automatic apply(input vec_t v);
    logic [30:0] act;
    @(negedge clk);
    reset = v.rst; flush = v.fl;
    issue_valid = v.iv; issue_dest = v.id; issue_tag = v.it;
    commit_valid = v.cv; commit_dest = v.cd; commit_tag = v.ct; commit_value = v.cval;
    #1;
    act = {issue_ready, commit_ready, ld_busy_ic, ld_rob_entry, dest_ic, rob_entry_in,
           ld_busy_rob, ld_value, dest_rob, value_in};
    n_run++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", v.name, act, v.exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; commit_valid = 1'b0;
    issue_dest = '0; issue_tag = '0; commit_dest = '0; commit_tag = '0; commit_value = '0;

    tbl.push_back(mk("reset", 1, 0, 1, 3'd3, 3'd2, 1, 3'd3, 3'd2, 16'hBEEF,
                     0, 0, 0, 0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 8; i++) tbl.push_back(sweep($sformatf("sweep%0d", i), 3'(i)));
    tbl.push_back(idle("ready_c9"));
    tbl.push_back(issue("iss_r3_t5", 3'd3, 3'd5));
    tbl.push_back(commit("cmt_r3_t5", 3'd3, 3'd5, 16'h1234, 1));
    tbl.push_back(issue("iss_r3_t5b", 3'd3, 3'd5));
    tbl.push_back(issue("iss_r3_t6", 3'd3, 3'd6));
    tbl.push_back(commit("cmt_stale_t5", 3'd3, 3'd5, 16'hAAAA, 0));
    tbl.push_back(commit("cmt_r3_t6", 3'd3, 3'd6, 16'h5555, 1));
    tbl.push_back(issue("iss_r4_t0", 3'd4, 3'd0));
    tbl.push_back(mk("iss_r1_cmt_r4", 0, 0, 1, 3'd1, 3'd2, 1, 3'd4, 3'd0, 16'h0BEE,
                     1, 1, 3'd1, 3'd2, 0, 1, 3'd4, 16'h0BEE));
    tbl.push_back(mk("pend_clr_r4", 0, 0, 1, 3'd6, 3'd1, 1, 3'd6, 3'd1, 16'h6666,
                     0, 0, 0, 0, 1, 0, 3'd4, 16'h0));
    tbl.push_back(idle("ready_after_pend"));
    tbl.push_back(commit("r6_not_issued", 3'd6, 3'd1, 16'h0606, 0));
    tbl.push_back(issue("iss_r2_t3", 3'd2, 3'd3));
    tbl.push_back(mk("iss_cmt_same_r2", 0, 0, 1, 3'd2, 3'd7, 1, 3'd2, 3'd3, 16'h2222,
                     1, 1, 3'd2, 3'd7, 0, 1, 3'd2, 16'h2222));
    tbl.push_back(idle("no_pend_same"));
    tbl.push_back(commit("cmt_r2_old_t3", 3'd2, 3'd3, 16'h3333, 0));
    tbl.push_back(commit("cmt_r2_t7", 3'd2, 3'd7, 16'h7777, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // Flush during a pending-clear cycle: clear dropped, sweep follows.
    apply(issue("iss_r5_t4", 3'd5, 3'd4));
    apply(mk("iss_r6_cmt_r5", 0, 0, 1, 3'd6, 3'd1, 1, 3'd5, 3'd4, 16'h5A5A,
             1, 1, 3'd6, 3'd1, 0, 1, 3'd5, 16'h5A5A));
    apply(mk("flush_in_pend", 0, 1, 1, 3'd0, 3'd0, 1, 3'd0, 3'd0, 16'h1111,
             0, 0, 0, 0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 3; i++) apply(sweep($sformatf("fsweep%0d", i), 3'(i)));
    // Flush mid-sweep restarts the counter.
    apply(mk("flush_in_sweep", 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 8; i++) apply(sweep($sformatf("rsweep%0d", i), 3'(i)));
    apply(idle("ready_after_flush"));
    // R1 (tag 2) and R6 (tag 1) were busy before the flush; shadow must be cleared.
    apply(commit("cmt_r1_post_flush", 3'd1, 3'd2, 16'hC0DE, 0));
    apply(commit("cmt_r6_post_flush", 3'd6, 3'd1, 16'hD00D, 0));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
